// File: rtl/button_event_decoder_if.sv
// Signal bundle between the debounced button level and the gesture decoder.
// The decoder takes the slave modport; application logic takes the master modport.
interface button_event_decoder_if;
    logic i_btn;
    logic o_press;
    logic o_release;
    logic o_single_click;
    logic o_double_click;
    logic o_long_press;
    logic o_repeat;

    modport slave (
        input  i_btn,
        output o_press,
        output o_release,
        output o_single_click,
        output o_double_click,
        output o_long_press,
        output o_repeat
    );

    modport master (
        output i_btn,
        input  o_press,
        input  o_release,
        input  o_single_click,
        input  o_double_click,
        input  o_long_press,
        input  o_repeat
    );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a clean button level into single-cycle press/release/click/long-press pulses.
// Define BUTTON_EVENT_DECODER_AUTO_REPEAT_EN to add auto-repeat pulses during a long hold.
module button_event_decoder #(
    parameter int LONG_CLK_COUNT   = 12000000,
    parameter int DOUBLE_CLK_COUNT = 3000000,
    parameter int REPEAT_CLK_COUNT = 1200000
) (
    input logic clk,
    input logic rst,
    button_event_decoder_if.slave bus
);
    localparam int MAX_LD = (LONG_CLK_COUNT > DOUBLE_CLK_COUNT) ? LONG_CLK_COUNT : DOUBLE_CLK_COUNT;
    localparam int MAX_ALL = (MAX_LD > REPEAT_CLK_COUNT) ? MAX_LD : REPEAT_CLK_COUNT;
    localparam int CW = $clog2(MAX_ALL + 1);

    // Terminal values: the count entering a state is 0, so N cycles end when it reads N-1.
    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CLK_COUNT - 1);
    localparam logic [CW-1:0] DOUBLE_LAST = CW'(DOUBLE_CLK_COUNT - 1);
    localparam logic [CW-1:0] COUNT_SAT   = {CW{1'b1}};
`ifdef BUTTON_EVENT_DECODER_AUTO_REPEAT_EN
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CLK_COUNT - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        PRESSED1,
        WAIT2,
        PRESSED2,
        LONG_HELD
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic          r_btnPrev;
    logic          r_press;
    logic          r_release;
    logic          r_singleClick;
    logic          r_doubleClick;
    logic          r_longPress;
`ifdef BUTTON_EVENT_DECODER_AUTO_REPEAT_EN
    logic          r_repeat;
`endif

    logic w_rise;
    logic w_fall;

    assign w_rise = bus.i_btn & ~r_btnPrev;
    assign w_fall = ~bus.i_btn & r_btnPrev;

    // Edges are tested before timeouts in every state so an edge on a terminal cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_btnPrev     <= 1'b0;
            r_press       <= 1'b0;
            r_release     <= 1'b0;
            r_singleClick <= 1'b0;
            r_doubleClick <= 1'b0;
            r_longPress   <= 1'b0;
`ifdef BUTTON_EVENT_DECODER_AUTO_REPEAT_EN
            r_repeat      <= 1'b0;
`endif
        end else begin
            r_btnPrev     <= bus.i_btn;
            r_press       <= 1'b0;
            r_release     <= 1'b0;
            r_singleClick <= 1'b0;
            r_doubleClick <= 1'b0;
            r_longPress   <= 1'b0;
`ifdef BUTTON_EVENT_DECODER_AUTO_REPEAT_EN
            r_repeat      <= 1'b0;
`endif
            if (r_count != COUNT_SAT) begin
                r_count <= r_count + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_press <= 1'b1;
                        r_state <= PRESSED1;
                        r_count <= '0;
                    end
                end
                PRESSED1: begin
                    if (w_fall) begin
                        r_release <= 1'b1;
                        r_state   <= WAIT2;
                        r_count   <= '0;
                    end else if (r_count == LONG_LAST) begin
                        r_longPress <= 1'b1;
                        r_state     <= LONG_HELD;
                        r_count     <= '0;
                    end
                end
                WAIT2: begin
                    if (w_rise) begin
                        r_press <= 1'b1;
                        r_state <= PRESSED2;
                        r_count <= '0;
                    end else if (r_count == DOUBLE_LAST) begin
                        r_singleClick <= 1'b1;
                        r_state       <= IDLE;
                        r_count       <= '0;
                    end
                end
                PRESSED2: begin
                    if (w_fall) begin
                        r_release     <= 1'b1;
                        r_doubleClick <= 1'b1;
                        r_state       <= IDLE;
                        r_count       <= '0;
                    end else if (r_count == LONG_LAST) begin
                        r_longPress <= 1'b1;
                        r_state     <= LONG_HELD;
                        r_count     <= '0;
                    end
                end
                LONG_HELD: begin
                    if (w_fall) begin
                        r_release <= 1'b1;
                        r_state   <= IDLE;
                        r_count   <= '0;
                    end
`ifdef BUTTON_EVENT_DECODER_AUTO_REPEAT_EN
                    else if (r_count == REPEAT_LAST) begin
                        r_repeat <= 1'b1;
                        r_count  <= '0;
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign bus.o_press        = r_press;
    assign bus.o_release      = r_release;
    assign bus.o_single_click = r_singleClick;
    assign bus.o_double_click = r_doubleClick;
    assign bus.o_long_press   = r_longPress;
`ifdef BUTTON_EVENT_DECODER_AUTO_REPEAT_EN
    assign bus.o_repeat       = r_repeat;
`else
    assign bus.o_repeat       = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder: directed gestures, then random button runs,
// all checked against a timestamp-based gesture model.
module tb_button_event_decoder;
    localparam int LONG   = 20;
    localparam int DOUBLE = 8;
    localparam int REPEAT = 5;
`ifdef BUTTON_EVENT_DECODER_AUTO_REPEAT_EN
    localparam bit AUTO_REPEAT = 1'b1;
`else
    localparam bit AUTO_REPEAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    button_event_decoder_if bus ();

    button_event_decoder #(
        .LONG_CLK_COUNT  (LONG),
        .DOUBLE_CLK_COUNT(DOUBLE),
        .REPEAT_CLK_COUNT(REPEAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model state: gesture progress expressed as timestamps of the last press, release and pulse.
    int t;
    bit prevB, pending, second, longFired;
    int pressT, relT, repT;
    bit eP, eR, eS, eD, eL, eRep;

    task automatic modelReset();
        prevB = 0; pending = 0; second = 0; longFired = 0;
        pressT = 0; relT = 0; repT = 0;
        {eP, eR, eS, eD, eL, eRep} = '0;
    endtask

    task automatic modelStep(input bit b);
        bit rise, fall;
        t++;
        rise = b && !prevB;
        fall = !b && prevB;
        {eP, eR, eS, eD, eL, eRep} = '0;
        eP = rise;
        eR = fall;
        if (rise) begin
            pressT    = t;
            second    = pending;
            pending   = 0;
            longFired = 0;
        end else if (fall) begin
            if (!longFired) begin
                if (second) begin
                    eD     = 1;
                    second = 0;
                end else begin
                    pending = 1;
                    relT    = t;
                end
            end
            longFired = 0;
        end else if (b) begin
            if (!longFired && (t - pressT == LONG)) begin
                eL        = 1;
                longFired = 1;
                second    = 0;
                repT      = t;
            end else if (longFired && AUTO_REPEAT && (t - repT == REPEAT)) begin
                eRep = 1;
                repT = t;
            end
        end else if (pending && (t - relT == DOUBLE)) begin
            eS      = 1;
            pending = 0;
        end
        prevB = b;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic checkOutput();
        int clicks;
        check("press",   bus.o_press,        eP);
        check("release", bus.o_release,      eR);
        check("single",  bus.o_single_click, eS);
        check("double",  bus.o_double_click, eD);
        check("long",    bus.o_long_press,   eL);
        check("repeat",  bus.o_repeat,       eRep);
        clicks = int'(bus.o_single_click) + int'(bus.o_double_click)
               + int'(bus.o_long_press) + int'(bus.o_repeat);
        check("exclusive", logic'(clicks <= 1), 1'b1);
    endtask

    task automatic checkZero(input string tag);
        check({tag, "_press"},   bus.o_press,        1'b0);
        check({tag, "_release"}, bus.o_release,      1'b0);
        check({tag, "_single"},  bus.o_single_click, 1'b0);
        check({tag, "_double"},  bus.o_double_click, 1'b0);
        check({tag, "_long"},    bus.o_long_press,   1'b0);
        check({tag, "_repeat"},  bus.o_repeat,       1'b0);
    endtask

    // One clock cycle: drive btn away from the edge, advance the model, check at the falling edge.
    task automatic applyStimulus(input bit b);
        bus.i_btn = b;
        @(posedge clk);
        modelStep(b);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic runLevel(input bit b, input int n);
        for (int i = 0; i < n; i++) applyStimulus(b);
    endtask

    initial begin
        t = 0;
        rst = 1'b1;
        bus.i_btn = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkZero("reset");
        rst = 1'b0;

        $display("[TB] short press -> single click");
        runLevel(1, 5);  runLevel(0, 12);

        $display("[TB] two short presses -> double click");
        runLevel(1, 3);  runLevel(0, 4);  runLevel(1, 3);  runLevel(0, 10);

        $display("[TB] 30-cycle hold -> long press");
        runLevel(1, 30); runLevel(0, 10);

        $display("[TB] 35-cycle hold -> long press and repeats when enabled");
        runLevel(1, 35); runLevel(0, 10);

        $display("[TB] fall on the long-press terminal cycle");
        runLevel(1, 20); runLevel(0, 12);

        $display("[TB] second press on the double-click terminal cycle");
        runLevel(1, 3);  runLevel(0, 8);  runLevel(1, 3);  runLevel(0, 10);

        $display("[TB] long hold during second press discards the click");
        runLevel(1, 2);  runLevel(0, 3);  runLevel(1, 25); runLevel(0, 12);

        $display("[TB] reset during double-click window, btn high through reset release");
        runLevel(1, 3);
        applyStimulus(0);
        #2 rst = 1'b1;
        #1 checkZero("asyncrst");
        modelReset();
        bus.i_btn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkZero("inrst");
        rst = 1'b0;
        runLevel(1, 3);  runLevel(0, 12);

        $display("[TB] random button runs");
        for (int r = 0; r < 60; r++) begin
            runLevel(r[0] ? 1'b0 : 1'b1, $urandom_range(1, 30));
        end
        runLevel(0, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
